// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_basic controller between NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to enable the transaction watchdog (err / i2c_reset).
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [2*NUM_REQ-1:0]    req_num_wr,
    input  logic [24*NUM_REQ-1:0]   req_wr_data,
    input  logic [2*NUM_REQ-1:0]    req_num_rd,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      ack,
    output logic [15:0]             rd_data,
    output logic                    err,
    output logic [6:0]              i2c_addr,
    output logic [1:0]              i2c_num_wr_bytes,
    output logic [7:0]              i2c_wr_data0,
    output logic [7:0]              i2c_wr_data1,
    output logic [7:0]              i2c_wr_data2,
    output logic [1:0]              i2c_num_rd_bytes,
    output logic                    i2c_start,
    input  logic                    i2c_done,
    input  logic [7:0]              i2c_rd_data0,
    input  logic [7:0]              i2c_rd_data1,
    output logic                    i2c_reset
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK, S_GAP
    } state_e;

    state_e               state_q;
    logic [IW-1:0]        ptr_q, ptr_d, win_idx;
    logic                 found;
    int                   idx, sel;
    logic [6:0]           w_addr;
    logic [1:0]           w_nwr, w_nrd, w_nrd_eff;
    logic [23:0]          w_wd;
    logic                 w_null;

    logic [NUM_REQ-1:0]   grant_q, ack_q;
    logic [15:0]          rd_data_q;
    logic [6:0]           addr_q;
    logic [1:0]           nwr_q, nrd_q;
    logic [7:0]           wd0_q, wd1_q, wd2_q;
    logic                 start_q, i2c_reset_q;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          to_hit;
    assign to_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

    // First set request at or after the pointer, wrapping around
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                found   = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        sel       = int'(win_idx);
        w_addr    = req_addr[7*sel +: 7];
        w_nwr     = req_num_wr[2*sel +: 2];
        w_nrd     = req_num_rd[2*sel +: 2];
        w_wd      = req_wr_data[24*sel +: 24];
        w_nrd_eff = (w_nwr != 2'd0) ? 2'd0 :
                    (w_nrd == 2'd3) ? 2'd2 : w_nrd;
        w_null    = (w_nwr == 2'd0) && (w_nrd == 2'd0);
        ptr_d     = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            rd_data_q   <= '0;
            addr_q      <= '0;
            nwr_q       <= '0;
            nrd_q       <= '0;
            wd0_q       <= '0;
            wd1_q       <= '0;
            wd2_q       <= '0;
            start_q     <= 1'b0;
            i2c_reset_q <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            start_q     <= 1'b0;
            ack_q       <= '0;
            i2c_reset_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        grant_q <= NUM_REQ'(1) << win_idx;
                        addr_q  <= w_addr;
                        nwr_q   <= w_nwr;
                        nrd_q   <= w_nrd_eff;
                        wd0_q   <= w_wd[7:0];
                        wd1_q   <= w_wd[15:8];
                        wd2_q   <= w_wd[23:16];
                        ptr_q   <= ptr_d;
`ifdef I2C_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (w_null) begin
                            rd_data_q <= '0;
                            state_q   <= S_ACK;
                        end else begin
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b1;
                    state_q <= S_WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT_BUSY: begin
                    if (!i2c_done) begin
                        state_q <= S_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (to_hit) begin
                        i2c_reset_q <= 1'b1;
                        rd_data_q   <= '0;
                        err_q       <= 1'b1;
                        state_q     <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (i2c_done) begin
                        rd_data_q <= {i2c_rd_data0, i2c_rd_data1};
                        state_q   <= S_ACK;
`ifdef I2C_ARB_TIMEOUT_EN
                    end else if (to_hit) begin
                        i2c_reset_q <= 1'b1;
                        rd_data_q   <= '0;
                        err_q       <= 1'b1;
                        state_q     <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_ACK: begin
                    ack_q   <= grant_q;
`ifdef I2C_ARB_TIMEOUT_EN
                    // Second cycle of the controller reset after a timeout
                    i2c_reset_q <= err_q;
`endif
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant            = grant_q;
    assign ack              = ack_q;
    assign rd_data          = rd_data_q;
    assign i2c_addr         = addr_q;
    assign i2c_num_wr_bytes = nwr_q;
    assign i2c_num_rd_bytes = nrd_q;
    assign i2c_wr_data0     = wd0_q;
    assign i2c_wr_data1     = wd1_q;
    assign i2c_wr_data2     = wd2_q;
    assign i2c_start        = start_q;
    assign i2c_reset        = i2c_reset_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: behavioural i2c_basic model plus scoreboard queue.
// Define I2C_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_i2c_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [7*N-1:0]  req_addr = '0;
    logic [2*N-1:0]  req_num_wr = '0;
    logic [24*N-1:0] req_wr_data = '0;
    logic [2*N-1:0]  req_num_rd = '0;
    logic [N-1:0]    grant, ack;
    logic [15:0]     rd_data;
    logic            err;
    logic [6:0]      i2c_addr;
    logic [1:0]      i2c_num_wr_bytes, i2c_num_rd_bytes;
    logic [7:0]      i2c_wr_data0, i2c_wr_data1, i2c_wr_data2;
    logic            i2c_start;
    logic            i2c_done = 1'b1;
    logic [7:0]      i2c_rd_data0 = '0, i2c_rd_data1 = '0;
    logic            i2c_reset;

    int checks = 0;
    int errors = 0;

    i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .req_num_wr(req_num_wr), .req_wr_data(req_wr_data),
        .req_num_rd(req_num_rd), .grant(grant), .ack(ack),
        .rd_data(rd_data), .err(err), .i2c_addr(i2c_addr),
        .i2c_num_wr_bytes(i2c_num_wr_bytes), .i2c_wr_data0(i2c_wr_data0),
        .i2c_wr_data1(i2c_wr_data1), .i2c_wr_data2(i2c_wr_data2),
        .i2c_num_rd_bytes(i2c_num_rd_bytes), .i2c_start(i2c_start),
        .i2c_done(i2c_done), .i2c_rd_data0(i2c_rd_data0),
        .i2c_rd_data1(i2c_rd_data1), .i2c_reset(i2c_reset)
    );

    always #5 clk = ~clk;

    // i2c_basic model: done idles high, drops on start, rises m_lat cycles later
    logic [7:0] m_d0 = 8'h00, m_d1 = 8'h00;
    bit         m_hang = 1'b0;
    int         m_lat = 4;
    int         m_cnt = 0;
    int         n_start = 0;

    always @(posedge clk) begin
        if (i2c_start) n_start <= n_start + 1;
        if (!reset_n || i2c_reset) begin
            i2c_done <= 1'b1;
            m_cnt    <= 0;
        end else if (i2c_start) begin
            i2c_done <= 1'b0;
            m_cnt    <= m_lat;
        end else if (!i2c_done && !m_hang) begin
            if (m_cnt == 0) begin
                i2c_done     <= 1'b1;
                i2c_rd_data0 <= m_d0;
                i2c_rd_data1 <= m_d1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        int          owner;
        logic [6:0]  addr;
        logic [1:0]  nwr;
        logic [7:0]  w0, w1;
        logic [1:0]  nrd;
        logic [15:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    task automatic set_req(input int i, input logic [6:0] a, input logic [1:0] nw,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] nr);
        req_addr[7*i +: 7]     = a;
        req_num_wr[2*i +: 2]   = nw;
        req_wr_data[24*i +: 24] = {8'h00, b1, b0};
        req_num_rd[2*i +: 2]   = nr;
    endtask

    task automatic push_exp(input int i, input logic [15:0] rd, input logic e_err);
        exp_t e;
        logic [1:0] nw, nr;
        nw = req_num_wr[2*i +: 2];
        nr = req_num_rd[2*i +: 2];
        e.owner = i;
        e.addr  = req_addr[7*i +: 7];
        e.nwr   = nw;
        e.w0    = req_wr_data[24*i +: 8];
        e.w1    = req_wr_data[24*i+8 +: 8];
        e.nrd   = (nw != 0) ? 2'd0 : (nr == 2'd3 ? 2'd2 : nr);
        e.rd    = rd;
        e.err   = e_err;
        sbq.push_back(e);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rst_ack: got %b want 0000", ack); end
        checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", i2c_start); end
        checks++; if (i2c_reset !== 1'b1) begin errors++; $display("FAIL rst_i2c_reset: got %b want 1", i2c_reset); end
        checks++; if ({rd_data, err, i2c_addr} !== 24'h0) begin errors++; $display("FAIL rst_outs: got %h want 0", {rd_data, err, i2c_addr}); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (i2c_reset !== 1'b0) begin errors++; $display("FAIL rst_release: got %b want 0", i2c_reset); end
    endtask

    task automatic test_round_robin;
        int acks = 0, starts = 0, s0;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 7'(7'h20 + i), 2'd1, 8'(8'hA0 + i), 8'h00, 2'd0);
        m_d0 = 8'h11; m_d1 = 8'h22;
        for (int k = 0; k < 5; k++) push_exp(order[k], 16'h1122, 1'b0);
        s0 = n_start;
        req = 4'b1111;
        for (int c = 0; c < 300 && acks < 5; c++) begin
            @(negedge clk);
            if (i2c_start === 1'b1 && sbq.size() > 0) begin
                starts++;
                checks++; if (i2c_addr !== sbq[0].addr) begin errors++; $display("FAIL rr_addr: got %h want %h", i2c_addr, sbq[0].addr); end
                checks++; if (grant !== 4'(1 << sbq[0].owner)) begin errors++; $display("FAIL rr_grant: got %b want owner %0d", grant, sbq[0].owner); end
            end
            if (ack !== 4'b0 && sbq.size() > 0) begin
                exp_t e = sbq.pop_front();
                acks++;
                checks++; if (ack !== 4'(1 << e.owner)) begin errors++; $display("FAIL rr_ack: got %b want owner %0d", ack, e.owner); end
                checks++; if (rd_data !== e.rd) begin errors++; $display("FAIL rr_rd: got %h want %h", rd_data, e.rd); end
                if (acks == 5) req = '0;
            end
        end
        checks++; if (acks != 5) begin errors++; $display("FAIL rr_acks: got %0d want 5", acks); end
        checks++; if (n_start - s0 != 5 || starts != 5) begin errors++; $display("FAIL rr_starts: got %0d want 5", n_start - s0); end
        sbq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int st_cyc = -1, acks = 0, starts = 0;
        set_req(0, 7'h1A, 2'd2, 8'h10, 8'h55, 2'd0);
        m_d0 = 8'h00; m_d1 = 8'h00;
        push_exp(0, 16'h0000, 1'b0);
        req[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wr_grant: got %b want 0001", grant); end
            end
            if (i2c_start === 1'b1) begin
                starts++;
                if (st_cyc < 0) st_cyc = c;
                checks++; if ({i2c_addr, i2c_num_wr_bytes, i2c_wr_data0, i2c_wr_data1, i2c_num_rd_bytes} !==
                              {sbq[0].addr, sbq[0].nwr, sbq[0].w0, sbq[0].w1, sbq[0].nrd}) begin
                    errors++; $display("FAIL wr_cmd: got %h/%0d/%h/%h/%0d want %h/%0d/%h/%h/%0d",
                        i2c_addr, i2c_num_wr_bytes, i2c_wr_data0, i2c_wr_data1, i2c_num_rd_bytes,
                        sbq[0].addr, sbq[0].nwr, sbq[0].w0, sbq[0].w1, sbq[0].nrd);
                end
            end
            if (ack !== 4'b0) begin
                acks++;
                if (sbq.size() > 0) begin
                    exp_t e = sbq.pop_front();
                    checks++; if (ack !== 4'(1 << e.owner)) begin errors++; $display("FAIL wr_ack: got %b want owner %0d", ack, e.owner); end
                end
                req[0] = 1'b0;
            end
        end
        checks++; if (st_cyc != 2) begin errors++; $display("FAIL wr_start_lat: got %0d want 2", st_cyc); end
        checks++; if (acks != 1 || starts != 1) begin errors++; $display("FAIL wr_once: got acks %0d starts %0d want 1 1", acks, starts); end
    endtask

    task automatic test_read;
        int acks = 0;
        set_req(1, 7'h50, 2'd0, 8'h00, 8'h00, 2'd2);
        m_d0 = 8'hBE; m_d1 = 8'hEF;
        push_exp(1, 16'hBEEF, 1'b0);
        req[1] = 1'b1;
        for (int c = 1; c <= 40 && acks == 0; c++) begin
            @(negedge clk);
            if (i2c_start === 1'b1) begin
                checks++; if (i2c_num_rd_bytes !== sbq[0].nrd) begin errors++; $display("FAIL rd_nrd: got %0d want %0d", i2c_num_rd_bytes, sbq[0].nrd); end
            end
            if (ack !== 4'b0) begin
                exp_t e = sbq.pop_front();
                acks++;
                req[1] = 1'b0;
                checks++; if (ack !== 4'(1 << e.owner)) begin errors++; $display("FAIL rd_ack: got %b want owner %0d", ack, e.owner); end
                checks++; if (rd_data !== e.rd) begin errors++; $display("FAIL rd_data: got %h want %h", rd_data, e.rd); end
                checks++; if (err !== e.err) begin errors++; $display("FAIL rd_err: got %b want %b", err, e.err); end
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL rd_ack_seen: got %0d want 1", acks); end
        repeat (3) @(negedge clk);
        checks++; if (rd_data !== 16'hBEEF || ack !== 4'b0) begin errors++; $display("FAIL rd_hold: got %h want beef", rd_data); end
    endtask

    task automatic test_clamp;
        int who [2] = '{3, 2};
        set_req(3, 7'h61, 2'd0, 8'h00, 8'h00, 2'd3);
        set_req(2, 7'h62, 2'd1, 8'h77, 8'h00, 2'd2);
        for (int k = 0; k < 2; k++) begin
            int acks = 0;
            push_exp(who[k], 16'hBEEF, 1'b0);
            req[who[k]] = 1'b1;
            for (int c = 1; c <= 40 && acks == 0; c++) begin
                @(negedge clk);
                if (i2c_start === 1'b1) begin
                    checks++; if (i2c_num_rd_bytes !== sbq[0].nrd) begin errors++; $display("FAIL clamp_nrd%0d: got %0d want %0d", k, i2c_num_rd_bytes, sbq[0].nrd); end
                end
                if (ack !== 4'b0) begin
                    exp_t e = sbq.pop_front();
                    acks++;
                    req[who[k]] = 1'b0;
                    checks++; if (ack !== 4'(1 << e.owner)) begin errors++; $display("FAIL clamp_ack%0d: got %b want owner %0d", k, ack, e.owner); end
                end
            end
            checks++; if (acks != 1) begin errors++; $display("FAIL clamp_done%0d: got %0d want 1", k, acks); end
            @(negedge clk);
        end
    endtask

    task automatic test_null;
        int s0, ack_cyc = -1;
        set_req(2, 7'h33, 2'd0, 8'h00, 8'h00, 2'd0);
        push_exp(2, 16'h0000, 1'b0);
        s0 = n_start;
        req[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack !== 4'b0 && ack_cyc < 0) begin
                exp_t e = sbq.pop_front();
                ack_cyc = c;
                req[2] = 1'b0;
                checks++; if (ack !== 4'(1 << e.owner)) begin errors++; $display("FAIL null_ack: got %b want owner %0d", ack, e.owner); end
                checks++; if (rd_data !== e.rd) begin errors++; $display("FAIL null_rd: got %h want %h", rd_data, e.rd); end
            end
        end
        checks++; if (ack_cyc != 2) begin errors++; $display("FAIL null_lat: got %0d want 2", ack_cyc); end
        checks++; if (n_start != s0) begin errors++; $display("FAIL null_nostart: got %0d want 0", n_start - s0); end
    endtask

    task automatic test_reset_abort;
        int acks = 0, seen = 0;
        m_lat = 30;
        set_req(1, 7'h44, 2'd0, 8'h00, 8'h00, 2'd1);
        req[1] = 1'b1;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (i2c_start === 1'b1) seen = 1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL abort_start: got %0d want 1", seen); end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({grant, i2c_start, i2c_reset, ack} !== {4'b0, 1'b0, 1'b1, 4'b0}) begin
            errors++; $display("FAIL abort_state: got g=%b s=%b r=%b a=%b want 0 0 1 0", grant, i2c_start, i2c_reset, ack);
        end
        reset_n = 1'b1;
        req = '0;
        m_lat = 4;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) acks++;
        end
        checks++; if (acks != 0 || i2c_reset !== 1'b0) begin errors++; $display("FAIL abort_noack: got %0d acks rst %b want 0 0", acks, i2c_reset); end
        set_req(3, 7'h3C, 2'd1, 8'h99, 8'h00, 2'd0);
        m_d0 = 8'h5A; m_d1 = 8'hA5;
        push_exp(3, 16'h5AA5, 1'b0);
        req[3] = 1'b1;
        for (int c = 0; c < 40 && acks == 0; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                exp_t e = sbq.pop_front();
                acks++;
                req[3] = 1'b0;
                checks++; if (ack !== 4'(1 << e.owner) || rd_data !== e.rd) begin
                    errors++; $display("FAIL abort_next: got %b/%h want owner %0d/%h", ack, rd_data, e.owner, e.rd);
                end
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL abort_next_seen: got %0d want 1", acks); end
        @(negedge clk);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int st = -1, ak = -1, rst_hi = 0, acks = 0;
        m_hang = 1'b1;
        set_req(0, 7'h2B, 2'd1, 8'h01, 8'h00, 2'd0);
        push_exp(0, 16'h0000, 1'b1);
        req[0] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (i2c_start === 1'b1 && st < 0) st = c;
            if (i2c_reset === 1'b1) rst_hi++;
            if (ack !== 4'b0 && ak < 0) begin
                exp_t e = sbq.pop_front();
                ak = c;
                req[0] = 1'b0;
                checks++; if (err !== e.err || rd_data !== e.rd) begin errors++; $display("FAIL to_err: got %b/%h want %b/%h", err, rd_data, e.err, e.rd); end
            end
        end
        checks++; if (ak < 0 || ak - st < 64 || ak - st > 72) begin errors++; $display("FAIL to_lat: got %0d want 64..72", ak - st); end
        checks++; if (rst_hi != 2) begin errors++; $display("FAIL to_rst: got %0d want 2", rst_hi); end
        m_hang = 1'b0;
        push_exp(0, {m_d0, m_d1}, 1'b0);
        req[0] = 1'b1;
        for (int c = 0; c < 40 && acks == 0; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                exp_t e = sbq.pop_front();
                acks++;
                req[0] = 1'b0;
                checks++; if (err !== e.err || rd_data !== e.rd) begin errors++; $display("FAIL to_next: got %b/%h want %b/%h", err, rd_data, e.err, e.rd); end
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL to_next_seen: got %0d want 1", acks); end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_read();
        test_clamp();
        test_null();
        test_reset_abort();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
